// File: rtl/cgra_pkg.sv
// Platform-wide constants used by the CGRA memory-side blocks.
package cgra_pkg;

  // Read data returned for accesses that fall outside the memory window.
  localparam logic [31:0] OBI_MEM_OOB_DATA  = 32'hBADC_AB1E;
  localparam logic [15:0] OBI_MEM_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by OBI masters and responders.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_mem_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) producing a grant-permit bit;
// only instantiated when OBI_MEM_STALL_EN is defined.
module obi_mem_lfsr
  import cgra_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output logic grant_ok
);

  logic [15:0] state;
  logic        fb;

  assign fb = state[0] ^ state[2] ^ state[3] ^ state[5];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= OBI_MEM_LFSR_SEED;
    end else begin
      state <= {fb, state[15:1]};
    end
  end

  // A grant is withheld whenever the two low state bits are both zero.
  assign grant_ok = (state[1:0] != 2'b00);

endmodule

// File: rtl/obi_mem_responder.sv
// OBI word-memory responder with a fixed-latency in-order response pipeline.
// Define OBI_MEM_STALL_EN to add pseudo-random grant stalls driven by an LFSR.
module obi_mem_responder
  import obi_pkg::*;
  import cgra_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    req_i,
  output obi_resp_t   resp_o,
  output logic [31:0] txn_count_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic              allow;
  logic              gnt;
  logic [31:0]       byte_off;
  logic [31:0]       word_off;
  logic [AW-1:0]     idx;
  logic              in_range;
  logic [31:0]       rsp_data;
  logic [31:0]       mem [MEM_WORDS];
  logic [LATENCY-1:0] vld_p;
  logic [31:0]       dat_p [LATENCY];
  logic [31:0]       txn_count;

`ifdef OBI_MEM_STALL_EN
  obi_mem_lfsr u_lfsr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .grant_ok (allow)
  );
`else
  assign allow = 1'b1;
`endif

  // Grant is held low while in reset so nothing is accepted then.
  assign gnt = req_i.req & rst_ni & allow;

  // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
  assign byte_off = req_i.addr - BASE_ADDR;
  assign word_off = byte_off >> 2;
  assign idx      = word_off[AW-1:0];
  assign in_range = (word_off < 32'(MEM_WORDS));

  // Byte-enabled write on the grant edge; memory is never reset.
  always_ff @(posedge clk_i) begin
    if (gnt && req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_i.be[b]) begin
          mem[idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    if (!req_i.we) begin
      rsp_data = in_range ? mem[idx] : OBI_MEM_OOB_DATA;
    end
  end

  // Stage p0 captures the response at grant; later stages just shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= gnt;
      for (int s = 1; s < int'(LATENCY); s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    dat_p[0] <= rsp_data;
    for (int s = 1; s < int'(LATENCY); s++) begin
      dat_p[s] <= dat_p[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txn_count <= '0;
    end else if (gnt) begin
      txn_count <= txn_count + 32'd1;
    end
  end

  assign txn_count_o = txn_count;

  // Data stages are not reset, so rdata is masked by the final valid bit.
  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = gnt;
    resp_o.rvalid = vld_p[LATENCY-1];
    resp_o.rdata  = vld_p[LATENCY-1] ? dat_p[LATENCY-1] : 32'h0;
  end

endmodule
